dm_dbg_responder: RTL and testbench

- Memory-side responder for the serial debug unit's data-memory port.
- Samples the debug unit's slow load strobe (dbg_clk_ld) together with addr/din/we.
- Performs the requested single-word read or write on a synchronous-read data memory, borrowing the memory port from the core (sorter/CPU) and stalling the core when needed.
- Returns read data on dbg_dout and holds it until the next access.

---
 rtl/dm_dbg_responder.sv | 129 ++++++++++++
 tb/tb_dm_dbg_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dbg_responder.sv
// Memory-side responder for the serial debug unit's data-memory port: one word
// access per strobe pulse, core stalled around it. Optional: DM_DBG_ACC_CNT_EN.
module dm_dbg_responder #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   dbg_addr,
  input  logic [DW-1:0] dbg_din,
  input  logic          dbg_we,
  input  logic          dbg_clk_ld,
  output logic [DW-1:0] dbg_dout,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_we,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
`ifdef DM_DBG_ACC_CNT_EN
  ,
  output logic [15:0]   dbg_acc_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, STALL, ACCESS, CAPTURE, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic [2:0]    ld_valid;
  logic          ld_rise;
  logic [31:0]   lat_addr;
  logic [DW-1:0] lat_din;
  logic          lat_we;
  logic          in_range;

  // ld_valid marks when sync3 holds a real post-reset sample, so a strobe
  // already high at reset release is never mistaken for a rising edge.
  assign ld_rise    = sync2 & ~sync3 & ld_valid[2];
  assign in_range   = (lat_addr[31:AW] == '0);
  assign core_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      ld_valid <= 3'b000;
    end else begin
      sync1    <= dbg_clk_ld;
      sync2    <= sync1;
      sync3    <= sync2;
      ld_valid <= {ld_valid[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_addr <= '0;
      lat_din  <= '0;
      lat_we   <= 1'b0;
    end else if (state == IDLE && ld_rise) begin
      lat_addr <= dbg_addr;
      lat_din  <= dbg_din;
      lat_we   <= dbg_we;
    end
  end

  // Stall is registered from the next state so it is glitch-free towards the core.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      core_stall <= 1'b0;
    end else begin
      state      <= state_nxt;
      core_stall <= (state_nxt == STALL) || (state_nxt == ACCESS) ||
                    (state_nxt == CAPTURE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_dout <= '0;
    end else if (state == CAPTURE) begin
      dbg_dout <= in_range ? mem_rdata : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_rise) state_nxt = STALL;
      STALL:   state_nxt = ACCESS;
      ACCESS:  state_nxt = lat_we ? HOLD : CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (!sync2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The core owns the port except during the single debug ACCESS cycle.
  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_we    = core_we;
    if (state == ACCESS) begin
      mem_addr  = lat_addr[AW-1:0];
      mem_wdata = lat_din;
      mem_we    = lat_we & in_range;
    end
  end

`ifdef DM_DBG_ACC_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_acc_cnt <= '0;
    end else if (state == ACCESS) begin
      dbg_acc_cnt <= dbg_acc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_dbg_responder.sv
// Directed bench for dm_dbg_responder with a synchronous-read memory and a
// simple core that writes a new word every unstalled cycle.
module tb_dm_dbg_responder;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   dbg_addr;
  logic [DW-1:0] dbg_din;
  logic          dbg_we;
  logic          dbg_clk_ld;
  logic [DW-1:0] dbg_dout;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_we;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
`ifdef DM_DBG_ACC_CNT_EN
  logic [15:0]   dbg_acc_cnt;
`endif

  logic [31:0]   mem [0:(1<<AW)-1] = '{default: 32'h0};
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  logic          core_active;
  int            core_idx = 0;

  int            vectors = 0;
  int            miscompares = 0;
  int            stall_count;
  int            stall_first;
  int            we_count;
  int            we_first;
  logic [31:0]   dout_at [0:63];

  always #5 clk = ~clk;

  dm_dbg_responder #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .dbg_addr   (dbg_addr),
    .dbg_din    (dbg_din),
    .dbg_we     (dbg_we),
    .dbg_clk_ld (dbg_clk_ld),
    .dbg_dout   (dbg_dout),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
`ifdef DM_DBG_ACC_CNT_EN
    ,
    .dbg_acc_cnt(dbg_acc_cnt)
`endif
  );

  // Memory with a back-door write port used only for preloading.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  assign core_addr  = 10'd100 + core_idx[9:0];
  assign core_wdata = 32'hC0DE_0000 | 32'(core_idx);
  assign core_we    = core_active;

  always @(posedge clk) begin
    if (core_active && !core_stall) core_idx <= core_idx + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise the strobe before posedge 1, keep it high for 'hold' samples, and
  // record what the DUT shows at each following negedge.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] din,
                                input logic we, input int hold);
    dbg_addr = addr;
    dbg_din  = din;
    dbg_we   = we;
    stall_count = 0;
    stall_first = 0;
    we_count    = 0;
    we_first    = 0;
    @(negedge clk);
    dbg_clk_ld = 1'b1;
    for (int k = 1; k <= hold + 6; k++) begin
      @(negedge clk);
      if (core_stall) begin
        stall_count++;
        if (stall_first == 0) stall_first = k;
      end
      if (mem_we) begin
        we_count++;
        if (we_first == 0) we_first = k;
      end
      dout_at[k] = dbg_dout;
      if (k == hold) dbg_clk_ld = 1'b0;
    end
  endtask

  initial begin
    int errs;
    int cnt_stall;
    int cnt_we;
    dbg_addr = '0;
    dbg_din = '0;
    dbg_we = 1'b0;
    dbg_clk_ld = 1'b0;
    core_active = 1'b0;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;

    @(negedge clk);
    bd_we = 1'b1;
    bd_addr = 10'd0;
    bd_data = 32'hA5A5_A5A5;
    @(negedge clk);
    bd_we = 1'b0;
    check_output("reset_stall", 32'(core_stall), 32'd0);
    check_output("reset_dout", dbg_dout, 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] debug write then read back");
    apply_stimulus(32'd5, 32'hDEAD_BEEF, 1'b1, 8);
    check_output("wr_stall_cycles", 32'(stall_count), 32'd2);
    check_output("wr_stall_first", 32'(stall_first), 32'd3);
    check_output("wr_we_pulses", 32'(we_count), 32'd1);
    check_output("wr_we_cycle", 32'(we_first), 32'd4);
    check_output("wr_mem5", mem[5], 32'hDEAD_BEEF);
    check_output("wr_dout_kept", dout_at[12], 32'h0);

    apply_stimulus(32'd5, 32'h0, 1'b0, 8);
    check_output("rd_stall_cycles", 32'(stall_count), 32'd3);
    check_output("rd_stall_first", 32'(stall_first), 32'd3);
    check_output("rd_we_pulses", 32'(we_count), 32'd0);
    check_output("rd_dout_early", dout_at[5], 32'h0);
    check_output("rd_dout", dout_at[6], 32'hDEAD_BEEF);

    $display("[TB] out-of-range access");
    apply_stimulus(32'h0000_0400, 32'h1234_5678, 1'b1, 8);
    check_output("oor_we_pulses", 32'(we_count), 32'd0);
    check_output("oor_stall_cycles", 32'(stall_count), 32'd2);
    check_output("oor_mem0", mem[0], 32'hA5A5_A5A5);
    check_output("oor_dout_kept", dout_at[12], 32'hDEAD_BEEF);
`ifdef DM_DBG_ACC_CNT_EN
    check_output("cnt_three", 32'(dbg_acc_cnt), 32'd3);
`endif
    apply_stimulus(32'h0000_0400, 32'h0, 1'b0, 8);
    check_output("oor_rd_early", dout_at[5], 32'hDEAD_BEEF);
    check_output("oor_rd_dout", dout_at[6], 32'h0);

    $display("[TB] debug read while core writes every cycle");
    @(negedge clk);
    core_active = 1'b1;
    repeat (3) @(negedge clk);
    apply_stimulus(32'd5, 32'h0, 1'b0, 8);
    core_active = 1'b0;
    @(negedge clk);
    check_output("core_stall_cycles", 32'(stall_count), 32'd3);
    check_output("core_rd_dout", dout_at[6], 32'hDEAD_BEEF);
    errs = 0;
    for (int i = 0; i < core_idx; i++) begin
      if (mem[100 + i] !== (32'hC0DE_0000 | 32'(i))) errs++;
    end
    check_output("core_writes_kept", 32'(errs), 32'd0);
    check_output("core_no_extra", mem[100 + core_idx], 32'h0);
    check_output("core_progress", 32'(core_idx > 10), 32'd1);

    $display("[TB] long strobe");
    apply_stimulus(32'd9, 32'h9999_0009, 1'b1, 50);
    check_output("long_we_pulses", 32'(we_count), 32'd1);
    check_output("long_stall_cycles", 32'(stall_count), 32'd2);
    check_output("long_mem9", mem[9], 32'h9999_0009);

    $display("[TB] reset during STALL");
    dbg_addr = 32'd7;
    dbg_din = 32'h7777_7777;
    dbg_we = 1'b1;
    @(negedge clk);
    dbg_clk_ld = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_pre_stall", 32'(core_stall), 32'd1);
    rstn = 1'b0;
    #1;
    check_output("rst_stall_clear", 32'(core_stall), 32'd0);
    check_output("rst_dout_clear", dbg_dout, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cnt_stall = 0;
    cnt_we = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (core_stall) cnt_stall++;
      if (mem_we) cnt_we++;
    end
    check_output("rst_high_strobe_stall", 32'(cnt_stall), 32'd0);
    check_output("rst_high_strobe_we", 32'(cnt_we), 32'd0);
    check_output("rst_mem7", mem[7], 32'h0);
    dbg_clk_ld = 1'b0;
    repeat (4) @(negedge clk);

    apply_stimulus(32'd5, 32'h0, 1'b0, 8);
    check_output("recover_rd_dout", dout_at[6], 32'hDEAD_BEEF);

`ifdef DM_DBG_ACC_CNT_EN
    @(negedge clk);
    force dut.dbg_acc_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.dbg_acc_cnt;
    apply_stimulus(32'd5, 32'h0, 1'b0, 8);
    check_output("cnt_wrap", 32'(dbg_acc_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
